// File: rtl/canvas_input_ctrl.sv
// -----------------------------------------------------------------------------
// canvas_input_ctrl
//
// Canvas front-end: turns raw button / RGB-toggle lines into cursor moves,
// colour changes and queued pixel-write requests.
//
// Each of the 8 raw inputs passes through a 2-flop synchroniser and a
// per-bit debouncer. Rising edges of the debounced levels become one-cycle
// event pulses, gated by ena. Direction pulses move a wrapping cursor
// (modulo CANVAS_W / CANVAS_H). Toggle pulses XOR the colour bits.
// Draw pulses, and cursor moves while draw is held, push
// {x, y, colour} into a show-ahead FIFO that drains over a valid/ready port.
//
// Optional feature macro: CANVAS_AUTO_REPEAT_EN
//   Defined   : a held direction re-fires every REPEAT_CYCLES cycles, timed
//               by one shared counter that any new direction press restarts.
//   Undefined : one move per press; no repeat counter exists.
//
// Handshake (wr_*): the head entry is offered while wr_valid=1. It is
// consumed on a clock edge where wr_valid && wr_ready. While wr_valid=1 and
// wr_ready=0 the head (wr_x, wr_y, wr_color) and wr_valid hold steady.
// wr_valid never drops without a pop.
//
// Ports
//   clk       in   1   clock
//   rst_n     in   1   synchronous active-low reset
//   ena       in   1   event enable (0 suppresses all button events)
//   btn_in    in   8   raw inputs: [0] up [1] down [2] left [3] right
//                      [4] draw [5] R toggle [6] G toggle [7] B toggle
//   cursor_x  out  XW  cursor column
//   cursor_y  out  YW  cursor row
//   color     out  3   colour {B,G,R}
//   wr_valid  out  1   FIFO head valid
//   wr_ready  in   1   consumer accepts head
//   wr_x      out  XW  head column
//   wr_y      out  YW  head row
//   wr_color  out  3   head colour
//   overflow  out  1   sticky: a request was dropped
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module canvas_input_ctrl #(
    parameter int CANVAS_W        = 64,
    parameter int CANVAS_H        = 64,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_CYCLES   = 4096,
    localparam int XW             = $clog2(CANVAS_W),
    localparam int YW             = $clog2(CANVAS_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic [7:0]    btn_in,
    output logic [XW-1:0] cursor_x,
    output logic [YW-1:0] cursor_y,
    output logic [2:0]    color,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [XW-1:0] wr_x,
    output logic [YW-1:0] wr_y,
    output logic [2:0]    wr_color,
    output logic          overflow
);

    // Reject illegal configurations at elaboration time.
    generate
        if (CANVAS_W < 2 || CANVAS_H < 2 || DEBOUNCE_CYCLES < 1 ||
            FIFO_DEPTH < 2 || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
            REPEAT_CYCLES < 1) begin : g_param_err
            $error("canvas_input_ctrl: illegal parameter value");
        end
    endgenerate

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [XW-1:0] X_MAX   = XW'(CANVAS_W - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(CANVAS_H - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    // -------------------------------------------------------------------------
    // Synchroniser and debouncer
    // -------------------------------------------------------------------------
    logic [7:0]    r_sync1;
    logic [7:0]    r_sync2;
    logic [7:0]    r_stable;
    logic [7:0]    r_stable_d;
    logic [CW-1:0] r_db_cnt [8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            for (int i = 0; i < 8; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1    <= btn_in;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            for (int i = 0; i < 8; i++) begin
                // The counter only runs while the synced level disagrees with
                // the stable level; any agreement restarts the stability window.
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Rising edges of the debounced levels. The pulse is visible in the same
    // cycle the stable level rises, so the cursor updates on the next edge.
    logic [7:0] w_rise;
    logic [7:0] w_pulse;

    assign w_rise  = r_stable & ~r_stable_d;
    assign w_pulse = ena ? w_rise : 8'h00;

    // -------------------------------------------------------------------------
    // Direction move requests (optionally with auto-repeat)
    // -------------------------------------------------------------------------
    logic [3:0] w_move;

`ifdef CANVAS_AUTO_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] r_rep_cnt;
    logic          w_dir_held;
    logic          w_dir_press;
    logic          w_rep_fire;

    assign w_dir_held  = |r_stable[3:0];
    assign w_dir_press = |w_rise[3:0];
    // A fresh press restarts the period, so the repeat never coincides with it.
    assign w_rep_fire  = w_dir_held && !w_dir_press && (r_rep_cnt == REP_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rep_cnt <= '0;
        end else if (w_dir_press || !w_dir_held || w_rep_fire) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end

    // Repeats apply to every direction still held, so conflict rules hold.
    assign w_move = w_pulse[3:0] | ({4{w_rep_fire & ena}} & r_stable[3:0]);
`else
    assign w_move = w_pulse[3:0];
`endif

    // -------------------------------------------------------------------------
    // Cursor and colour
    // -------------------------------------------------------------------------
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [2:0]    r_color;
    logic [XW-1:0] w_next_x;
    logic [YW-1:0] w_next_y;
    logic [2:0]    w_next_color;

    // Opposing directions in the same cycle cancel out on that axis.
    always_comb begin
        w_next_x = r_x;
        if (w_move[2] && !w_move[3]) begin
            w_next_x = (r_x == '0) ? X_MAX : (r_x - 1'b1);
        end else if (w_move[3] && !w_move[2]) begin
            w_next_x = (r_x == X_MAX) ? '0 : (r_x + 1'b1);
        end
    end

    always_comb begin
        w_next_y = r_y;
        if (w_move[0] && !w_move[1]) begin
            w_next_y = (r_y == '0) ? Y_MAX : (r_y - 1'b1);
        end else if (w_move[1] && !w_move[0]) begin
            w_next_y = (r_y == Y_MAX) ? '0 : (r_y + 1'b1);
        end
    end

    assign w_next_color = r_color ^ {w_pulse[7], w_pulse[6], w_pulse[5]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
        end else begin
            r_x     <= w_next_x;
            r_y     <= w_next_y;
            r_color <= w_next_color;
        end
    end

    assign cursor_x = r_x;
    assign cursor_y = r_y;
    assign color    = r_color;

    // -------------------------------------------------------------------------
    // Write request generation
    // -------------------------------------------------------------------------
    logic w_cursor_moves;
    logic w_push;

    assign w_cursor_moves = (w_next_x != r_x) || (w_next_y != r_y);
    assign w_push         = w_pulse[4] || (r_stable[4] && w_cursor_moves);

    // -------------------------------------------------------------------------
    // Show-ahead FIFO
    // -------------------------------------------------------------------------
    logic [XW-1:0] r_mem_x [FIFO_DEPTH];
    logic [YW-1:0] r_mem_y [FIFO_DEPTH];
    logic [2:0]    r_mem_c [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          w_full;
    logic          w_pop;
    logic          w_do_push;

    assign w_full    = (r_count == FULL_CNT);
    assign w_pop     = (r_count != '0) && wr_ready;
    // When full, a push only fits if the head leaves in the same cycle.
    assign w_do_push = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_x[i] <= '0;
                r_mem_y[i] <= '0;
                r_mem_c[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem_x[r_wr_ptr] <= w_next_x;
                r_mem_y[r_wr_ptr] <= w_next_y;
                r_mem_c[r_wr_ptr] <= w_next_color;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && !w_do_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign wr_valid = (r_count != '0);
    assign wr_x     = r_mem_x[r_rd_ptr];
    assign wr_y     = r_mem_y[r_rd_ptr];
    assign wr_color = r_mem_c[r_rd_ptr];
    assign overflow = r_overflow;

endmodule
